// File: rtl/drive_ramp_pwm.sv
// drive_ramp_pwm: soft-start PWM drive for the left/right wheel motors.
// The base duty ramps between 0 and MAX_DUTY in STEP increments paced by
// ramp_tick. The right motor gets a signed trim. New duties are latched at
// the counter wrap so a period is never cut short. Emergency stop is the
// only exception and clears the outputs at once.
module drive_ramp_pwm #(
    parameter int PWM_BITS = 8,
    parameter int MAX_DUTY = 200,
    parameter int STEP     = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable_forward,
    input  logic                ramp_tick,
    input  logic                estop,
    input  logic [3:0]          trim,
    output logic                pwm_left,
    output logic                pwm_right,
    output logic [PWM_BITS-1:0] duty,
    output logic [1:0]          state,
    output logic                at_speed
);

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        RAMP_UP   = 2'b01,
        CRUISE    = 2'b10,
        RAMP_DOWN = 2'b11
    } state_t;

    localparam int                  TW      = PWM_BITS + 2;
    localparam logic [PWM_BITS:0]   STEP_G  = (PWM_BITS+1)'(STEP);
    localparam logic [PWM_BITS:0]   MAX_G   = (PWM_BITS+1)'(MAX_DUTY);
    localparam logic [PWM_BITS-1:0] MAX_D   = PWM_BITS'(MAX_DUTY);
    localparam logic [PWM_BITS-1:0] CNT_TOP = '1;

    state_t                state_q, state_d;
    logic [PWM_BITS-1:0]   duty_q, duty_d;
    logic [PWM_BITS-1:0]   cnt_q;
    logic [PWM_BITS-1:0]   act_l_q, act_r_q;
    logic                  pwm_l_q, pwm_r_q;

    // Guard bit on both ramp arithmetic paths so add/subtract never wrap.
    logic [PWM_BITS:0]     sum_up;
    logic signed [TW-1:0]  trim_sx, trim_sum;
    logic [PWM_BITS-1:0]   tgt_r;

    assign sum_up   = {1'b0, duty_q} + STEP_G;
    assign trim_sx  = {{(TW-4){trim[3]}}, trim};
    assign trim_sum = $signed({2'b00, duty_q}) + trim_sx;

    // Right-motor target: zero base duty stays zero, otherwise clamp duty+trim.
    always_comb begin
        tgt_r = '0;
        if (duty_q != '0) begin
            if (trim_sum[TW-1])
                tgt_r = '0;
            else if (trim_sum > $signed({2'b00, MAX_D}))
                tgt_r = MAX_D;
            else
                tgt_r = trim_sum[PWM_BITS-1:0];
        end
    end

    // Ramp FSM next state: estop first, then enable changes, then ramp ticks.
    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        if (estop) begin
            state_d = IDLE;
            duty_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable_forward) state_d = RAMP_UP;
                end
                RAMP_UP: begin
                    if (!enable_forward) begin
                        state_d = RAMP_DOWN;
                    end else if (ramp_tick) begin
                        if (sum_up >= MAX_G) begin
                            duty_d  = MAX_D;
                            state_d = CRUISE;
                        end else begin
                            duty_d  = sum_up[PWM_BITS-1:0];
                        end
                    end
                end
                CRUISE: begin
                    duty_d = MAX_D;
                    if (!enable_forward) state_d = RAMP_DOWN;
                end
                RAMP_DOWN: begin
                    if (enable_forward) begin
                        state_d = RAMP_UP;
                    end else if (ramp_tick) begin
                        if ({1'b0, duty_q} <= STEP_G) begin
                            duty_d  = '0;
                            state_d = IDLE;
                        end else begin
                            duty_d  = duty_q - STEP_G[PWM_BITS-1:0];
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM and base duty registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            duty_q  <= '0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
        end
    end

    // PWM counter, wrap-synchronous duty latch and registered compare outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q   <= '0;
            act_l_q <= '0;
            act_r_q <= '0;
            pwm_l_q <= 1'b0;
            pwm_r_q <= 1'b0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
            if (estop) begin
                act_l_q <= '0;
                act_r_q <= '0;
                pwm_l_q <= 1'b0;
                pwm_r_q <= 1'b0;
            end else begin
                pwm_l_q <= (cnt_q < act_l_q);
                pwm_r_q <= (cnt_q < act_r_q);
                if (cnt_q == CNT_TOP) begin
                    act_l_q <= duty_q;
                    act_r_q <= tgt_r;
                end
            end
        end
    end

    assign pwm_left  = pwm_l_q;
    assign pwm_right = pwm_r_q;
    assign duty      = duty_q;
    assign state     = state_q;
    assign at_speed  = (state_q == CRUISE);

endmodule

// File: tb/tb_drive_ramp_pwm.sv
// Bench for drive_ramp_pwm: two instances (STEP=50 and STEP=60) share one
// stimulus stream; a cycle-level reference model checks every output each
// cycle, plus directed checks of ramp sequences, PWM high counts, trim and estop.
module tb_drive_ramp_pwm;

    localparam int MAXD   = 200;
    localparam int PERIOD = 256;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable_forward = 1'b0;
    logic       ramp_tick = 1'b0;
    logic       estop = 1'b0;
    logic [3:0] trim = 4'd0;

    logic       pwm_l [2];
    logic       pwm_r [2];
    logic [7:0] duty_o [2];
    logic [1:0] state_o [2];
    logic       spd_o [2];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state (per instance). States use the external codes.
    int steps [2] = '{50, 60};
    int m_state [2], m_duty [2], m_cnt [2], m_al [2], m_ar [2], m_pl [2], m_pr [2];

    always #5 clk = ~clk;

    drive_ramp_pwm #(.PWM_BITS(8), .MAX_DUTY(MAXD), .STEP(50)) u_dut0 (
        .clk(clk), .reset(reset), .enable_forward(enable_forward),
        .ramp_tick(ramp_tick), .estop(estop), .trim(trim),
        .pwm_left(pwm_l[0]), .pwm_right(pwm_r[0]), .duty(duty_o[0]),
        .state(state_o[0]), .at_speed(spd_o[0])
    );

    drive_ramp_pwm #(.PWM_BITS(8), .MAX_DUTY(MAXD), .STEP(60)) u_dut1 (
        .clk(clk), .reset(reset), .enable_forward(enable_forward),
        .ramp_tick(ramp_tick), .estop(estop), .trim(trim),
        .pwm_left(pwm_l[1]), .pwm_right(pwm_r[1]), .duty(duty_o[1]),
        .state(state_o[1]), .at_speed(spd_o[1])
    );

    task automatic chk(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int trim_val();
        return (trim >= 4'd8) ? int'(trim) - 16 : int'(trim);
    endfunction

    function automatic int right_target(input int d);
        int t;
        if (d == 0) return 0;
        t = d + trim_val();
        if (t < 0) t = 0;
        if (t > MAXD) t = MAXD;
        return t;
    endfunction

    // One clock edge of the behavioural model, from the rules in plain ints.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                m_state[i] = 0; m_duty[i] = 0; m_cnt[i] = 0;
                m_al[i] = 0; m_ar[i] = 0; m_pl[i] = 0; m_pr[i] = 0;
            end else begin
                if (estop) begin
                    m_pl[i] = 0; m_pr[i] = 0; m_al[i] = 0; m_ar[i] = 0;
                end else begin
                    m_pl[i] = (m_cnt[i] < m_al[i]) ? 1 : 0;
                    m_pr[i] = (m_cnt[i] < m_ar[i]) ? 1 : 0;
                    if (m_cnt[i] == PERIOD - 1) begin
                        m_al[i] = m_duty[i];
                        m_ar[i] = right_target(m_duty[i]);
                    end
                end
                m_cnt[i] = (m_cnt[i] + 1) % PERIOD;
                if (estop) begin
                    m_state[i] = 0; m_duty[i] = 0;
                end else if (m_state[i] == 0) begin
                    if (enable_forward) m_state[i] = 1;
                end else if (m_state[i] == 1) begin
                    if (!enable_forward) m_state[i] = 3;
                    else if (ramp_tick) begin
                        m_duty[i] = (m_duty[i] + steps[i] > MAXD) ? MAXD : m_duty[i] + steps[i];
                        if (m_duty[i] == MAXD) m_state[i] = 2;
                    end
                end else if (m_state[i] == 2) begin
                    if (!enable_forward) m_state[i] = 3;
                end else begin
                    if (enable_forward) m_state[i] = 1;
                    else if (ramp_tick) begin
                        m_duty[i] = (m_duty[i] - steps[i] < 0) ? 0 : m_duty[i] - steps[i];
                        if (m_duty[i] == 0) m_state[i] = 0;
                    end
                end
            end
        end
    endtask

    // Advance one cycle, update the model on the edge and compare 1 time unit later.
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("d%0d.state", i), int'(state_o[i]), m_state[i]);
            chk($sformatf("d%0d.duty", i), int'(duty_o[i]), m_duty[i]);
            chk($sformatf("d%0d.at_speed", i), int'(spd_o[i]), (m_state[i] == 2) ? 1 : 0);
            chk($sformatf("d%0d.pwm_left", i), int'(pwm_l[i]), m_pl[i]);
            chk($sformatf("d%0d.pwm_right", i), int'(pwm_r[i]), m_pr[i]);
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic count_pwm(output int cl, output int cr);
        cl = 0; cr = 0;
        for (int k = 0; k < PERIOD; k++) begin
            cyc();
            cl += int'(pwm_l[0]);
            cr += int'(pwm_r[0]);
        end
    endtask

    task automatic tick();
        ramp_tick = 1'b1;
        cyc();
        ramp_tick = 1'b0;
    endtask

    initial begin
        int exp0 [4];
        int exp1 [4];
        int cl, cr;

        // Reset held low for 4 cycles.
        run(4);
        chk("rst.state", int'(state_o[0]), 0);
        chk("rst.duty", int'(duty_o[0]), 0);
        chk("rst.pwm", int'(pwm_l[0]) + int'(pwm_r[0]), 0);
        reset = 1'b1;

        // Start: IDLE -> RAMP_UP with duty still 0.
        enable_forward = 1'b1;
        cyc();
        chk("start.state", int'(state_o[0]), 1);
        chk("start.duty", int'(duty_o[0]), 0);

        // Ramp up: STEP=50 and STEP=60 (saturating) sequences.
        exp0 = '{50, 100, 150, 200};
        exp1 = '{60, 120, 180, 200};
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("up50.duty%0d", k), int'(duty_o[0]), exp0[k]);
            chk($sformatf("up60.duty%0d", k), int'(duty_o[1]), exp1[k]);
        end
        chk("up.state", int'(state_o[0]), 2);
        chk("up.at_speed", int'(spd_o[0]), 1);
        chk("up60.state", int'(state_o[1]), 2);

        // Cruise duty: 200 of 256 high; ticks ignored.
        tick();
        chk("cruise.tick_ignored", int'(duty_o[0]), 200);
        run(300);
        count_pwm(cl, cr);
        chk("cruise.left_high", cl, 200);
        chk("cruise.right_high", cr, 200);

        // Trim in cruise.
        trim = 4'b1000;
        run(300);
        count_pwm(cl, cr);
        chk("trim_m8.right_high", cr, 192);
        chk("trim_m8.left_high", cl, 200);
        trim = 4'd7;
        run(300);
        count_pwm(cl, cr);
        chk("trim_p7.right_high", cr, 200);

        // Drop enable together with a tick: tick ignored, then ramp down.
        enable_forward = 1'b0;
        tick();
        chk("down.state", int'(state_o[0]), 3);
        chk("down.duty", int'(duty_o[0]), 200);
        exp0 = '{150, 100, 50, 0};
        exp1 = '{140, 80, 20, 0};
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("dn50.duty%0d", k), int'(duty_o[0]), exp0[k]);
            chk($sformatf("dn60.duty%0d", k), int'(duty_o[1]), exp1[k]);
        end
        chk("down.idle", int'(state_o[0]), 0);

        // Zero duty with positive trim: right output never high.
        run(300);
        count_pwm(cl, cr);
        chk("zero_trim.right_high", cr, 0);

        // Estop mid-period in cruise with enable held.
        trim = 4'd0;
        enable_forward = 1'b1;
        cyc();
        for (int k = 0; k < 4; k++) tick();
        run(300 + int'($urandom_range(0, 200)));
        chk("estop.pre_state", int'(state_o[0]), 2);
        estop = 1'b1;
        cyc();
        chk("estop.pwm_left", int'(pwm_l[0]), 0);
        chk("estop.pwm_right", int'(pwm_r[0]), 0);
        chk("estop.duty", int'(duty_o[0]), 0);
        chk("estop.state", int'(state_o[0]), 0);
        run(5);
        chk("estop.hold_state", int'(state_o[0]), 0);
        estop = 1'b0;
        cyc();
        chk("estop.release_state", int'(state_o[0]), 1);

        // Reset mid-ramp at duty 100.
        tick();
        tick();
        chk("rst_mid.pre_duty", int'(duty_o[0]), 100);
        reset = 1'b0;
        cyc();
        chk("rst_mid.state", int'(state_o[0]), 0);
        chk("rst_mid.duty", int'(duty_o[0]), 0);
        chk("rst_mid.at_speed", int'(spd_o[0]), 0);
        reset = 1'b1;

        // Randomized phase against the model.
        for (int k = 0; k < 5000; k++) begin
            if (($urandom % 40) == 0) enable_forward = ~enable_forward;
            ramp_tick = (($urandom % 6) == 0);
            if (($urandom % 150) == 0) estop = ~estop;
            else if (estop && ($urandom % 8) == 0) estop = 1'b0;
            if (($urandom % 100) == 0) trim = 4'($urandom);
            reset = (($urandom % 400) != 0);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
